// File: rtl/bram_row_uart_serializer.sv
// bram_row_uart_serializer: reads BRAM rows on port B and streams them LSB byte first to uart_tx; SER_ROW_CHECKSUM_EN appends a per-row XOR byte
module bram_row_uart_serializer #(
  parameter int DATA_W   = 1028,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_num_rows,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_cenb,
  output logic [ADDR_W-1:0] o_mem_addrb,
  input  logic [DATA_W-1:0] i_mem_doutb,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_done
);
  localparam int BPR = (DATA_W + 7) / 8;
  localparam int SW  = BPR * 8;
  localparam int BCW = $clog2(BPR + 1);
  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, SEND, WAIT_TX, ROW_END, DONE
`ifdef SER_ROW_CHECKSUM_EN
    , CHK
`endif
  } state_t;
  state_t            state, nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   rows_left;
  logic [1:0]        wait_cnt;
  logic [BCW-1:0]    byte_cnt;
  logic [SW-1:0]     shreg;
  logic              last_wait, last_byte, last_row;
`ifdef SER_ROW_CHECKSUM_EN
  logic [7:0]        chk;
  logic              chk_sent;
`endif
  assign last_wait   = wait_cnt == 2'(READ_LAT - 1);
  assign last_byte   = byte_cnt == BCW'(BPR - 1);
  assign last_row    = rows_left == (ADDR_W+1)'(1);
  assign o_busy      = state != IDLE;
  assign o_done      = state == DONE;
  assign o_mem_cenb  = state != RD_REQ;
  assign o_mem_addrb = cur_addr;
  assign o_tx_start  = state == SEND;
  assign o_tx_byte   = shreg[7:0];
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (i_start) nxt = (i_num_rows == '0) ? DONE : RD_REQ;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: if (last_wait) nxt = SEND;
      SEND:    nxt = WAIT_TX;
`ifdef SER_ROW_CHECKSUM_EN
      WAIT_TX: if (i_tx_done) nxt = chk_sent ? ROW_END : last_byte ? CHK : SEND;
      CHK:     nxt = SEND;
`else
      WAIT_TX: if (i_tx_done) nxt = last_byte ? ROW_END : SEND;
`endif
      ROW_END: nxt = last_row ? DONE : RD_REQ;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur_addr  <= '0;
      rows_left <= '0;
      wait_cnt  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
`ifdef SER_ROW_CHECKSUM_EN
      chk       <= '0;
      chk_sent  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (i_start) begin
          cur_addr  <= i_base_addr;
          rows_left <= i_num_rows;
        end
        RD_REQ: wait_cnt <= '0;
        RD_WAIT: if (last_wait) begin
          shreg    <= SW'(i_mem_doutb);
          byte_cnt <= '0;
`ifdef SER_ROW_CHECKSUM_EN
          chk      <= '0;
          chk_sent <= 1'b0;
`endif
        end else wait_cnt <= wait_cnt + 2'd1;
        WAIT_TX: if (i_tx_done) begin
          shreg    <= shreg >> 8;
          byte_cnt <= byte_cnt + BCW'(1);
`ifdef SER_ROW_CHECKSUM_EN
          chk      <= chk ^ shreg[7:0];
`endif
        end
`ifdef SER_ROW_CHECKSUM_EN
        CHK: begin
          shreg[7:0] <= chk;
          chk_sent   <= 1'b1;
        end
`endif
        ROW_END: begin
          rows_left <= rows_left - (ADDR_W+1)'(1);
          cur_addr  <= cur_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_row_uart_serializer.sv
// tb_bram_row_uart_serializer: table-driven and randomized transfers checked against a row/byte reference model
module tb_bram_row_uart_serializer;
  localparam int DW  = 1028;
  localparam int AW  = 8;
  localparam int RL  = 1;
  localparam int BPR = 129;
`ifdef SER_ROW_CHECKSUM_EN
  localparam int BTX = BPR + 1;
`else
  localparam int BTX = BPR;
`endif
  logic          i_clk, i_rst, i_start, i_tx_done;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_num_rows;
  logic          o_busy, o_done, o_mem_cenb, o_tx_start;
  logic [AW-1:0] o_mem_addrb;
  logic [DW-1:0] i_mem_doutb;
  logic [7:0]    o_tx_byte;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [3];
  logic [7:0]    got_bytes [$];
  int            got_reads [$];
  int cyc = 0, first_tx = -1, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int tx_cnt = 0, tx_delay = 1, n_vec = 0, n_err = 0;
  bit inject_spur = 0;
  typedef struct {
    int base; int num; int delay; int exp_bytes; int exp_reads; bit mid;
  } vec_t;
  vec_t vt [8];

  bram_row_uart_serializer #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_rows(i_num_rows), .o_busy(o_busy), .o_done(o_done), .o_mem_cenb(o_mem_cenb),
    .o_mem_addrb(o_mem_addrb), .i_mem_doutb(i_mem_doutb), .o_tx_start(o_tx_start),
    .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  assign i_mem_doutb = pipe[RL-1];
  always @(posedge i_clk) begin
    if (!o_mem_cenb) pipe[0] <= mem[o_mem_addrb];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  // uart_tx stand-in and output monitor, evaluated 1 time unit after each edge
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (tx_cnt > 0) begin
        tx_cnt--;
        i_tx_done = (tx_cnt == 0);
      end else i_tx_done = 0;
      if (o_tx_start) begin
        got_bytes.push_back(o_tx_byte);
        if (first_tx < 0) first_tx = cyc;
        tx_cnt = tx_delay;
        if (inject_spur) i_tx_done = 1;
      end
      if (!o_mem_cenb) got_reads.push_back(int'(o_mem_addrb));
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(int addr, int k);
    logic [BPR*8-1:0] row;
    logic [7:0] x;
    row = {{(BPR*8-DW){1'b0}}, mem[addr]};
    if (k < BPR) return row[8*k +: 8];
    x = 0;
    for (int j = 0; j < BPR; j++) x ^= row[8*j +: 8];
    return x;
  endfunction

  task automatic run_xfer(int base, int num, int delay, int exp_bytes, int exp_reads, bit mid);
    int budget, d0, addr, idx;
    bit pulsed;
    got_bytes.delete();
    got_reads.delete();
    first_tx = -1;
    tx_delay = delay;
    d0 = done_cnt;
    @(posedge i_clk); #2;
    i_base_addr = AW'(base);
    i_num_rows  = (AW+1)'(num);
    i_start     = 1;
    start_cyc   = cyc;
    @(posedge i_clk); #2;
    i_start = 0;
    budget = (num + 1) * BTX * (delay + 2) + 100;
    pulsed = 0;
    while (done_cnt == d0 && budget > 0) begin
      if (mid && !pulsed && got_bytes.size() >= 10) begin
        i_base_addr = 8'd99;
        i_num_rows  = 9'd7;
        i_start     = 1;
        pulsed      = 1;
      end else i_start = 0;
      @(posedge i_clk); #2;
      budget--;
    end
    i_start = 0;
    check("done_seen", 64'(done_cnt != d0), 1);
    check("busy_at_done", 64'(o_busy), 1);
    @(posedge i_clk); #2;
    check("busy_after_done", 64'(o_busy), 0);
    check("byte_count", 64'(got_bytes.size()), 64'(exp_bytes));
    check("read_count", 64'(got_reads.size()), 64'(exp_reads));
    for (int r = 0; r < num; r++) begin
      addr = (base + r) % 256;
      if (r < got_reads.size()) check("read_addr", 64'(got_reads[r]), 64'(addr));
      for (int k = 0; k < BTX; k++) begin
        idx = r * BTX + k;
        if (idx < got_bytes.size()) check("tx_byte", 64'(got_bytes[idx]), 64'(exp_byte(addr, k)));
      end
    end
    if (num == 0) check("zero_done_latency", 64'(done_cyc - start_cyc <= 2), 1);
    else check("first_tx_latency", 64'(first_tx - start_cyc), 64'(RL + 2));
    repeat (5) @(posedge i_clk);
    #2;
    check("done_pulses", 64'(done_cnt - d0), 1);
  endtask

  initial begin
    logic [1055:0] tmp;
    int b, n, budget, sz;
    i_rst = 1; i_start = 0; i_tx_done = 0; i_base_addr = 0; i_num_rows = 0;
    for (int a = 0; a < 256; a++) begin
      for (int w = 0; w < 33; w++) tmp[32*w +: 32] = $urandom;
      mem[a] = tmp[DW-1:0];
    end
    for (int k = 0; k < 128; k++) mem[5][8*k +: 8] = 8'(k + 1);
    mem[5][1027:1024] = 4'hA;
    repeat (3) @(posedge i_clk);
    #2 i_rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #2;
      check("rst_busy", 64'(o_busy), 0);
      check("rst_done", 64'(o_done), 0);
      check("rst_cenb", 64'(o_mem_cenb), 1);
      check("rst_addrb", 64'(o_mem_addrb), 0);
      check("rst_tx_start", 64'(o_tx_start), 0);
      check("rst_tx_byte", 64'(o_tx_byte), 0);
    end
    vt[0] = '{5, 1, 20, BTX, 1, 0};
    vt[1] = '{254, 3, 2, 3 * BTX, 3, 0};
    vt[2] = '{77, 0, 1, 0, 0, 0};
    vt[3] = '{5, 1, 3, BTX, 1, 1};
    for (int i = 4; i < 8; i++) begin
      b = int'($urandom_range(0, 255));
      n = int'($urandom_range(1, 2));
      vt[i] = '{b, n, int'($urandom_range(1, 3)), n * BTX, n, 0};
    end
    for (int i = 0; i < 8; i++) begin
      inject_spur = vt[i].mid;
      run_xfer(vt[i].base, vt[i].num, vt[i].delay, vt[i].exp_bytes, vt[i].exp_reads, vt[i].mid);
      if (i == 0 && got_bytes.size() > 128) begin
        check("row5_byte0", 64'(got_bytes[0]), 64'h01);
        check("row5_byte127", 64'(got_bytes[127]), 64'h80);
        check("row5_byte128", 64'(got_bytes[128]), 64'h0A);
      end
    end
    inject_spur = 0;
    got_bytes.delete();
    tx_delay = 2;
    @(posedge i_clk); #2;
    i_base_addr = 8'd10;
    i_num_rows  = 9'd2;
    i_start     = 1;
    @(posedge i_clk); #2;
    i_start = 0;
    budget = 2000;
    while (got_bytes.size() < 40 && budget > 0) begin
      @(posedge i_clk); #2;
      budget--;
    end
    check("reached_byte40", 64'(got_bytes.size() >= 40), 1);
    i_rst = 1;
    @(posedge i_clk); #2;
    i_rst = 0;
    check("midrst_busy", 64'(o_busy), 0);
    check("midrst_done", 64'(o_done), 0);
    check("midrst_cenb", 64'(o_mem_cenb), 1);
    check("midrst_addrb", 64'(o_mem_addrb), 0);
    check("midrst_tx_start", 64'(o_tx_start), 0);
    check("midrst_tx_byte", 64'(o_tx_byte), 0);
    sz = got_bytes.size();
    repeat (50) @(posedge i_clk);
    #2;
    check("no_tx_after_reset", 64'(got_bytes.size()), 64'(sz));
    check("idle_after_reset", 64'(o_busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
